// File: rtl/div_pkg.sv
// Shared definitions for the divide sequencing controller.
// State encoding, data widths and result field positions.
package div_pkg;

    localparam int DATA_W = 32;
    localparam int RES_W  = 2 * DATA_W;

    // {remainder, quotient} as returned by the divider
    localparam int REM_MSB = 63;
    localparam int REM_LSB = 32;
    localparam int QUO_MSB = 31;
    localparam int QUO_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] rem_of(input logic [RES_W-1:0] res);
        return res[REM_MSB:REM_LSB];
    endfunction

    function automatic logic [DATA_W-1:0] quo_of(input logic [RES_W-1:0] res);
        return res[QUO_MSB:QUO_LSB];
    endfunction

endpackage

// File: rtl/div_watchdog.sv
// RUN-state timer: pulses when the divider has run TIMEOUT cycles
// without being retired or flushed.
module div_watchdog #(
    parameter int TIMEOUT = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic timeout_pulse
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] timer;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            timer <= '0;
        end else if (run) begin
            timer <= timer + CNT_W'(1);
        end
    end

    assign timeout_pulse = run & (timer == LAST);

endmodule

// File: rtl/div_ctrl.sv
// Sequences one DIV/DIVU between EX and the multi-cycle divider,
// stalling EX and delivering {HI,LO} with a single write pulse.
module div_ctrl
    import div_pkg::*;
#(
    parameter int TIMEOUT      = 40,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_div_i,
    input  logic              ex_signed_i,
    input  logic [DATA_W-1:0] ex_rs_i,
    input  logic [DATA_W-1:0] ex_rt_i,
    input  logic              flush_i,
    output logic              div_start_o,
    output logic              div_cancel_o,
    output logic              div_signed_o,
    output logic [DATA_W-1:0] div_dividend_o,
    output logic [DATA_W-1:0] div_divider_o,
    input  logic [RES_W-1:0]  div_result_i,
    input  logic              div_success_i,
    output logic              stall_req_o,
    output logic              hilo_we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              err_o
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t             state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               launch;
    logic               running;
    logic               timeout_pulse;

    assign launch  = (state == IDLE) & ex_div_i & ~flush_i;
    assign running = (state == RUN);

    div_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .clear        (launch),
        .run          (running),
        .timeout_pulse(timeout_pulse)
    );

    assign div_start_o  = running;
    assign div_cancel_o = (state == DRAIN);
    // Issue-cycle term lets EX freeze before the operands are latched
    assign stall_req_o  = running | launch;
    assign hilo_we_o    = (state == DONE) & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            drain_cnt      <= '0;
            div_signed_o   <= 1'b0;
            div_dividend_o <= '0;
            div_divider_o  <= '0;
            hi_o           <= '0;
            lo_o           <= '0;
            err_o          <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        div_signed_o   <= ex_signed_i;
                        div_dividend_o <= ex_rs_i;
                        div_divider_o  <= ex_rt_i;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else if (div_success_i) begin
                        hi_o  <= rem_of(div_result_i);
                        lo_o  <= quo_of(div_result_i);
                        state <= DONE;
                    end else if (timeout_pulse) begin
                        err_o     <= 1'b1;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                // ex_div_i still names the retiring instruction here
                DONE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and random sequences for div_ctrl against a behavioural
// divider stub and an arithmetic reference model.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_div_i;
    logic        ex_signed_i;
    logic [31:0] ex_rs_i;
    logic [31:0] ex_rt_i;
    logic        flush_i;
    logic        div_start_o;
    logic        div_cancel_o;
    logic        div_signed_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divider_o;
    logic [63:0] div_result_i;
    logic        div_success_i;
    logic        stall_req_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        err_o;

    int n_assert = 0;
    int n_fail   = 0;
    int n_we     = 0;
    int stub_cnt = 0;
    int stub_lat = 2;
    bit stub_dead = 0;

    div_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ex_div_i      (ex_div_i),
        .ex_signed_i   (ex_signed_i),
        .ex_rs_i       (ex_rs_i),
        .ex_rt_i       (ex_rt_i),
        .flush_i       (flush_i),
        .div_start_o   (div_start_o),
        .div_cancel_o  (div_cancel_o),
        .div_signed_o  (div_signed_o),
        .div_dividend_o(div_dividend_o),
        .div_divider_o (div_divider_o),
        .div_result_i  (div_result_i),
        .div_success_i (div_success_i),
        .stall_req_o   (stall_req_o),
        .hilo_we_o     (hilo_we_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MIPS-style division: truncate toward zero, x/0 gives {0,0}
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a,
                                            input logic [31:0] b);
        int q;
        int r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    // Divider stub: success after stub_lat cycles of start, until start drops
    always @(posedge clk) begin
        if (rst || !div_start_o) stub_cnt <= 0;
        else if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
        if (hilo_we_o) n_we <= n_we + 1;
    end
    assign div_success_i = div_start_o && !stub_dead && (stub_cnt >= stub_lat);
    assign div_result_i  = ref_div(div_signed_o, div_dividend_o, div_divider_o);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (div_start_o && n < 200) begin
            tick();
            n++;
        end
        check("run_bound", 64'(n < 200), 64'd1);
    endtask

    task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input bit fl_done);
        logic [63:0] exp;
        int n;
        int we0;
        exp = ref_div(s, a, b);
        ex_div_i = 1'b1;
        ex_signed_i = s;
        ex_rs_i = a;
        ex_rt_i = b;
        #1;
        check("stall_issue", 64'(stall_req_o), 64'd1);
        check("start_issue", 64'(div_start_o), 64'd0);
        tick();
        ex_div_i = 1'b0;
        ex_rs_i = $urandom;
        ex_rt_i = $urandom;
        #1;
        check("start_run", 64'(div_start_o), 64'd1);
        check("stall_run", 64'(stall_req_o), 64'd1);
        check("op_a", 64'(div_dividend_o), 64'(a));
        check("op_b", 64'(div_divider_o), 64'(b));
        check("op_s", 64'(div_signed_o), 64'(s));
        we0 = n_we;
        wait_done(n);
        flush_i = fl_done;
        #1;
        check("done_we", 64'(hilo_we_o), 64'(!fl_done));
        check("done_stall", 64'(stall_req_o), 64'd0);
        check("done_start", 64'(div_start_o), 64'd0);
        check("hi", 64'(hi_o), 64'(exp[63:32]));
        check("lo", 64'(lo_o), 64'(exp[31:0]));
        tick();
        flush_i = 1'b0;
        #1;
        check("we_pulse", 64'(hilo_we_o), 64'd0);
        check("n_writes", 64'(n_we - we0), fl_done ? 64'd0 : 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {58'd0, div_start_o, div_cancel_o, stall_req_o,
                              hilo_we_o, err_o, div_signed_o}, 64'd0);
        check({tag, "_ops"}, {div_dividend_o, div_divider_o}, 64'd0);
        check({tag, "_hilo"}, {hi_o, lo_o}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int we0;
        bit s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;

        rst = 1'b1;
        ex_div_i = 1'b0;
        ex_signed_i = 1'b0;
        ex_rs_i = '0;
        ex_rt_i = '0;
        flush_i = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Directed values
        stub_lat = 5;
        do_div(1'b1, 32'd100, 32'd7, 1'b0);
        check("lo_100_7", 64'(lo_o), 64'd14);
        check("hi_100_7", 64'(hi_o), 64'd2);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("lo_m7_2", 64'(lo_o), 64'hFFFF_FFFD);
        check("hi_m7_2", 64'(hi_o), 64'hFFFF_FFFF);
        stub_lat = 0;
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("lo_u_max", 64'(lo_o), 64'hFFFF_FFFF);
        stub_lat = 3;
        do_div(1'b0, 32'd5, 32'd0, 1'b0);
        check("div0_hilo", {hi_o, lo_o}, 64'd0);

        // Flush ten cycles into RUN
        stub_lat = 30;
        we0 = n_we;
        ex_div_i = 1'b1;
        ex_signed_i = 1'b1;
        ex_rs_i = 32'd1000;
        ex_rt_i = 32'd3;
        tick();
        ex_div_i = 1'b0;
        repeat (9) tick();
        check("flush_pre_start", 64'(div_start_o), 64'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain_cancel", 64'(div_cancel_o), 64'd1);
            check("drain_quiet", {61'd0, div_start_o, stall_req_o, hilo_we_o}, 64'd0);
            tick();
        end
        check("drain_end", 64'(div_cancel_o), 64'd0);
        check("flush_nowrite", 64'(n_we - we0), 64'd0);
        stub_lat = 2;
        do_div(1'b1, 32'd9, 32'd3, 1'b0);
        check("post_flush_hilo", {hi_o, lo_o}, {32'd0, 32'd3});

        // Write suppressed by a flush in DONE
        do_div(1'b0, 32'd77, 32'd10, 1'b1);

        // Back-to-back with ex_div_i held through DONE
        stub_lat = 4;
        we0 = n_we;
        ex_div_i = 1'b1;
        ex_signed_i = 1'b0;
        ex_rs_i = 32'd50;
        ex_rt_i = 32'd6;
        tick();
        wait_done(n);
        check("b2b_done_we", 64'(hilo_we_o), 64'd1);
        check("b2b_done_start", 64'(div_start_o), 64'd0);
        check("b2b_done_stall", 64'(stall_req_o), 64'd0);
        check("b2b_first", {hi_o, lo_o}, {32'd2, 32'd8});
        tick();
        ex_signed_i = 1'b1;
        ex_rs_i = 32'hFFFF_FF9C;
        ex_rt_i = 32'd9;
        #1;
        check("b2b_idle_start", 64'(div_start_o), 64'd0);
        check("b2b_idle_stall", 64'(stall_req_o), 64'd1);
        tick();
        check("b2b_second_start", 64'(div_start_o), 64'd1);
        ex_div_i = 1'b0;
        wait_done(n);
        exp = ref_div(1'b1, 32'hFFFF_FF9C, 32'd9);
        check("b2b_second", {hi_o, lo_o}, exp);
        tick();
        check("b2b_writes", 64'(n_we - we0), 64'd2);

        // Random operands and latencies
        for (int k = 0; k < 24; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd7;
            stub_lat = $urandom_range(0, 10);
            do_div(s, a, b, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Divider never succeeds
        stub_dead = 1'b1;
        check("err_before", 64'(err_o), 64'd0);
        ex_div_i = 1'b1;
        ex_signed_i = 1'b0;
        ex_rs_i = 32'd8;
        ex_rt_i = 32'd2;
        tick();
        ex_div_i = 1'b0;
        wait_done(n);
        check("timeout_cycles", 64'(n), 64'd40);
        check("timeout_err", 64'(err_o), 64'd1);
        check("timeout_cancel", 64'(div_cancel_o), 64'd1);
        check("timeout_nowe", 64'(hilo_we_o), 64'd0);
        repeat (3) tick();
        check("timeout_idle", {62'd0, div_cancel_o, stall_req_o}, 64'd0);
        stub_dead = 1'b0;
        stub_lat = 1;
        do_div(1'b0, 32'd21, 32'd4, 1'b0);
        check("err_sticky", 64'(err_o), 64'd1);

        // Reset in the middle of RUN
        stub_lat = 20;
        ex_div_i = 1'b1;
        ex_rs_i = 32'd123;
        ex_rt_i = 32'd5;
        tick();
        ex_div_i = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_all_zero("rst_run");
        rst = 1'b0;
        tick();
        stub_lat = 2;
        do_div(1'b0, 32'd123, 32'd5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
